// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC engine: FSM encoding, mode values
// and the polynomial sanity check.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  // A usable generator needs both the x^CRC_W term and the constant term.
  function automatic logic poly_valid(input logic top_bit, input logic const_bit);
    return top_bit & const_bit;
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Input beat stream into the CRC engine.
// A beat transfers on a rising clk edge where in_valid && in_ready are both
// high; the source must hold in_valid/in_data/in_last stable until then.
interface crc_stream_engine_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/crc_step.sv
// Combinational CRC advance over BPC message bits, MSB (bits[BPC-1]) first.
module crc_step #(
  parameter int CRC_W = 4,
  parameter int BPC   = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [BPC-1:0]   bits,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ bits[i];
      c  = (c << 1) ^ (fb ? poly : '0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed CRC generator/checker: accepts DATA_W-bit beats, folds BPC bits per
// clock into a remainder against a runtime polynomial, reports once per frame.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int CRC_W  = 4,
  parameter int DATA_W = 8,
  parameter int BPC    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [CRC_W:0]      G,
  crc_stream_engine_if.slave  str,
  output logic                busy,
  output logic                done,
  output logic [CRC_W-1:0]    crc_out,
  output logic                error,
  output logic                cfg_err,
  output state_e              dbg_state
);

  localparam int BEATS = DATA_W / BPC;
  localparam int CNT_W = $clog2(BEATS + 1);

  if (DATA_W % BPC != 0) begin : g_bpc_check
    $error("crc_stream_engine: DATA_W must be a multiple of BPC");
  end

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [CRC_W-1:0]  poly_q, poly_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [CRC_W-1:0]  crc_out_q, crc_out_d;
  logic              error_q, error_d;
  logic              cfg_err_q, cfg_err_d;
  logic [CRC_W-1:0]  step_crc;

  crc_step #(.CRC_W(CRC_W), .BPC(BPC)) u_step (
    .crc_in  (crc_q),
    .bits    (sh_q[DATA_W-1 -: BPC]),
    .poly    (poly_q),
    .crc_out (step_crc)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    poly_d    = poly_q;
    crc_d     = crc_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    crc_out_d = crc_out_q;
    error_d   = error_q;
    cfg_err_d = cfg_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode;
          poly_d    = G[CRC_W-1:0];
          crc_d     = '0;
          crc_out_d = '0;
          error_d   = 1'b0;
          cfg_err_d = 1'b0;
          if (!poly_valid(G[CRC_W], G[0])) begin
            cfg_err_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        if (str.in_valid) begin
          sh_d    = str.in_data;
          last_d  = str.in_last;
          cnt_d   = CNT_W'(BEATS);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        crc_d = step_crc;
        sh_d  = sh_q << BPC;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Results are registered on entry to DONE so they are valid with done.
          if (last_q) begin
            state_d   = ST_DONE;
            crc_out_d = step_crc;
            error_d   = (mode_q == MODE_CHECK) && (step_crc != '0);
          end else begin
            state_d   = ST_ACCEPT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_GEN;
      poly_q    <= '0;
      crc_q     <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      crc_out_q <= '0;
      error_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      poly_q    <= poly_d;
      crc_q     <= crc_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      crc_out_q <= crc_out_d;
      error_q   <= error_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign str.in_ready = (state_q == ST_ACCEPT);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign crc_out      = crc_out_q;
  assign error        = error_q;
  assign cfg_err      = cfg_err_q;
  assign dbg_state    = state_q;

endmodule
